// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default geometry and the pointer-width helper.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 8;

    // Pointer width carries one extra wrap bit above the memory address.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// FIFO storage: synchronous write, asynchronous read, no reset on the array.
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata_c
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational; the caller registers it.
    assign rdata_c = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, level flags and count.
// Build option: define SYNC_FIFO_ERR_EN to add sticky overflow/underflow
// flags and their err_clr input.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AF_LEVEL   = DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         w_data,
    input  logic                          w_inc,
    input  logic                          r_inc,
    output logic [DATA_WIDTH-1:0]         r_data,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [ptr_width(DEPTH)-1:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic                          err_clr,
    output logic                          overflow,
    output logic                          underflow
`endif
);

    localparam int unsigned   PTR_W      = ptr_width(DEPTH);
    localparam int unsigned   ADDR_W     = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
    localparam logic          AF_AT_ZERO = (AF_LEVEL == 0);

    logic [PTR_W-1:0]      w_ptr;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      count_nxt;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] ram_rdata;

    fifo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (wr_ok),
        .waddr   (w_ptr[ADDR_W-1:0]),
        .wdata   (w_data),
        .raddr   (r_ptr[ADDR_W-1:0]),
        .rdata_c (ram_rdata)
    );

    // Accept decisions and next count; a simultaneous accept leaves count alone.
    always_comb begin
        wr_ok     = w_inc & ~full;
        rd_ok     = r_inc & ~empty;
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + PTR_W'(1);
            2'b01:   count_nxt = count - PTR_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, read data, count and flags; flags track the count being loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            r_data       <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= AF_AT_ZERO;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                r_ptr  <= r_ptr + PTR_W'(1);
                r_data <= ram_rdata;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_CNT);
            empty        <= (count_nxt == '0);
            almost_full  <= (32'(count_nxt) >= AF_LEVEL);
            almost_empty <= (32'(count_nxt) <= AE_LEVEL);
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_inc && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (r_inc && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    // Error flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at the default geometry (8 x 8, AF=7, AE=1).
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] w_data;
    logic       w_inc;
    logic       r_inc;
    logic [7:0] r_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic       err_clr;
    logic       overflow;
    logic       underflow;
`endif

    int errors = 0;
    int checks = 0;

    sync_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .w_data       (w_data),
        .w_inc        (w_inc),
        .r_inc        (r_inc),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int cnt);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".full"}, 32'(full), 32'(cnt == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(cnt >= 7));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= 1));
    endtask

    initial begin
        rst    = 1'b1;
        w_data = 8'h00;
        w_inc  = 1'b0;
        r_inc  = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        #2;
        chk_flags("reset", 0);
        chk("reset.r_data", 32'(r_data), 32'h00);
`ifdef SYNC_FIFO_ERR_EN
        chk("reset.overflow", 32'(overflow), 32'd0);
        chk("reset.underflow", 32'(underflow), 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;

        // Fill with 0x11..0x18.
        for (int i = 0; i < 8; i++) begin
            w_data = 8'(8'h11 + i);
            w_inc  = 1'b1;
            tick();
            chk_flags($sformatf("fill%0d", i), i + 1);
        end

        // Ninth write is rejected.
        w_data = 8'h99;
        tick();
        chk_flags("write_at_full", 8);
        chk("write_at_full.r_data", 32'(r_data), 32'h00);
`ifdef SYNC_FIFO_ERR_EN
        chk("write_at_full.overflow", 32'(overflow), 32'd1);
        w_inc   = 1'b0;
        err_clr = 1'b1;
        tick();
        chk("err_clr.overflow", 32'(overflow), 32'd0);
        err_clr = 1'b0;
`endif
        w_inc = 1'b0;

        // Drain, data in order with one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            r_inc = 1'b1;
            tick();
            chk($sformatf("drain%0d.r_data", i), 32'(r_data), 32'(8'h11 + i));
            chk($sformatf("drain%0d.count", i), 32'(count), 32'(7 - i));
        end
        r_inc = 1'b0;
        chk_flags("drained", 0);
        tick();
        chk("hold.r_data", 32'(r_data), 32'h18);

        // Refill, then simultaneous read/write at full.
        for (int i = 0; i < 8; i++) begin
            w_data = 8'(8'h21 + i);
            w_inc  = 1'b1;
            tick();
        end
        chk_flags("refill", 8);
        w_data = 8'hAA;
        r_inc  = 1'b1;
        tick();
        chk_flags("rw_at_full", 7);
        chk("rw_at_full.r_data", 32'(r_data), 32'h21);
        w_inc = 1'b0;

        // Drain the remaining seven; 0xAA must never appear.
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("drain2_%0d.r_data", i), 32'(r_data), 32'(8'h22 + i));
        end
        chk_flags("drained2", 0);

        // Simultaneous read/write at empty.
        w_data = 8'h55;
        w_inc  = 1'b1;
        r_inc  = 1'b1;
        tick();
        chk_flags("rw_at_empty", 1);
        chk("rw_at_empty.r_data", 32'(r_data), 32'h28);
`ifdef SYNC_FIFO_ERR_EN
        chk("rw_at_empty.underflow", 32'(underflow), 32'd1);
`endif
        w_inc = 1'b0;
        tick();
        chk("read_55.r_data", 32'(r_data), 32'h55);
        chk_flags("read_55", 0);
        r_inc = 1'b0;

        // Alternating write/read pairs across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            w_data = 8'(8'h30 + i);
            w_inc  = 1'b1;
            r_inc  = 1'b0;
            tick();
            chk($sformatf("alt%0d.count_w", i), 32'(count), 32'd1);
            w_inc = 1'b0;
            r_inc = 1'b1;
            tick();
            chk($sformatf("alt%0d.r_data", i), 32'(r_data), 32'(8'h30 + i));
            chk($sformatf("alt%0d.count_r", i), 32'(count), 32'd0);
        end
        r_inc = 1'b0;

        // Reset mid-stream with five words stored.
        for (int i = 0; i < 5; i++) begin
            w_data = 8'(8'h61 + i);
            w_inc  = 1'b1;
            tick();
        end
        chk_flags("five", 5);
        rst = 1'b1;
        #1;
        chk_flags("mid_reset", 0);
        chk("mid_reset.r_data", 32'(r_data), 32'h00);
        tick();
        rst   = 1'b0;
        w_inc = 1'b0;
        tick();
        chk_flags("after_reset", 0);
        w_data = 8'h77;
        w_inc  = 1'b1;
        tick();
        w_inc = 1'b0;
        r_inc = 1'b1;
        tick();
        r_inc = 1'b0;
        chk("after_reset.r_data", 32'(r_data), 32'h77);
        chk_flags("after_reset_rd", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width in bits of one stored word, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries, a power of two, minimum 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: count at or above which almost_full is 1.
REQ-004 SHALL have parameter AE_LEVEL, default 1: count at or below which almost_empty is 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port w_data, input, DATA_WIDTH bits: write data.
REQ-008 SHALL have port w_inc, input, 1 bit: write request.
REQ-009 SHALL have port r_inc, input, 1 bit: read request.
REQ-010 SHALL have port r_data, output, DATA_WIDTH bits: registered read data.
REQ-011 SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-012 SHALL have port empty, output, 1 bit: high when count equals 0.
REQ-013 SHALL have port almost_full, output, 1 bit: high when count >= AF_LEVEL.
REQ-014 SHALL have port almost_empty, output, 1 bit: high when count <= AE_LEVEL.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1 bits: current number of stored words.

Function
REQ-016 SHALL accept a write exactly when w_inc=1 and full=0; the word is stored at the write pointer and the pointer advances.
REQ-017 SHALL accept a read exactly when r_inc=1 and empty=0; the word at the read pointer is loaded into r_data on the same edge and the pointer advances, giving 1-cycle read latency.
REQ-018 SHALL hold r_data unchanged on any cycle without an accepted read.
REQ-019 SHALL keep read and write pointers clog2(DEPTH)+1 bits wide, address the memory with the low clog2(DEPTH) bits, and wrap modulo 2*DEPTH without a discontinuity.
REQ-020 SHALL update count by +1 on an accepted write only, by -1 on an accepted read only, and leave it unchanged when both are accepted on the same edge.
REQ-021 SHALL, when full, reject the write even if a read is accepted on the same edge; the read proceeds and count becomes DEPTH-1.
REQ-022 SHALL, when empty, reject the read even if a write is accepted on the same edge; r_data holds its value and count becomes 1.
REQ-023 SHALL drive full, empty, almost_full and almost_empty purely from registered count, so they change on the edge that changes count.
REQ-024 SHALL ignore rejected requests without corrupting any state.

Reset
REQ-025 SHALL, while rst=1 and regardless of clk, clear both pointers and count, drive r_data=0, empty=1, full=0, almost_empty=1, and almost_full=(AF_LEVEL==0).
REQ-026 SHALL discard in-flight contents when reset is asserted mid-operation; memory array contents are not reset and are unobservable afterwards.

Configuration
REQ-027 SHALL support macro SYNC_FIFO_ERR_EN; when it is defined, the block SHALL add output ports overflow and underflow (1 bit each) and input port err_clr (1 bit).
REQ-028 SHALL, with SYNC_FIFO_ERR_EN defined, set overflow sticky on a rejected write (w_inc=1, full=1) and underflow sticky on a rejected read (r_inc=1, empty=1); err_clr=1 or rst SHALL clear both, with set taking priority over err_clr on the same edge.
REQ-029 SHALL, without SYNC_FIFO_ERR_EN, omit those ports and flag registers entirely, with all other behaviour identical.

Structure
REQ-030 SHALL place the pointer-width function/constant and the default DATA_WIDTH and DEPTH values in shared package fifo_pkg.
REQ-031 SHALL isolate storage in one sub-module fifo_ram_dp, a synchronous-write, asynchronous-read array with no reset.

Verification
REQ-032 SHALL cover: reset, then write 0x11..0x18 with DEPTH=8 -> full=1, count=8, almost_full=1 after the 7th write; a 9th write is rejected.
REQ-033 SHALL cover: read 8 words -> r_data=0x11..0x18 each one cycle after its r_inc; empty=1 and almost_empty=1 at the end.
REQ-034 SHALL cover: at full, assert w_inc and r_inc together -> read accepted, write dropped, count=7.
REQ-035 SHALL cover: at empty, assert w_inc and r_inc together -> r_data unchanged, count=1.
REQ-036 SHALL cover: 20 alternating write/read pairs, forcing pointer wrap -> data order preserved and count never exceeds 1.
REQ-037 SHALL cover: assert rst mid-stream with count=5 -> outputs immediately at their reset values; with SYNC_FIFO_ERR_EN, a write at full sets overflow=1 and err_clr clears it.
